vector_store_buffer: RTL and testbench

Posted-write buffer between the vector CPU's store outputs and a single-port, 32-bit-wide data RAM. Each CPU store (scalar word or 4-lane vector) is captured in one cycle into a FIFO, then drained one 32-bit word per cycle to the RAM. The CPU is never stalled; overflow is flagged.

---
 rtl/vector_store_buffer_if.sv | 46 ++++
 rtl/vector_store_buffer.sv | 165 ++++++++++++++++
 tb/tb_vector_store_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_store_buffer_if.sv
// vector_store_buffer_if
// Groups the CPU store port and the RAM write port of the vector store buffer.
//   master : CPU/RAM side (drives stores, observes RAM writes and status)
//   slave  : the buffer itself
// Signals:
//   mem_wr_enable, wr_sc, wr_addr[31:0], wd1..wd4[31:0] : store request
//   ram_we, ram_addr[31:0], ram_wd[31:0]                : RAM write port
//   full, empty, overflow                               : status
//   rd_addr[31:0], rd_hazard                            : only with VSB_HAZARD_EN
interface vector_store_buffer_if;
    logic        mem_wr_enable;
    logic        wr_sc;
    logic [31:0] wr_addr;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic [31:0] wd3;
    logic [31:0] wd4;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wd;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef VSB_HAZARD_EN
    logic [31:0] rd_addr;
    logic        rd_hazard;
`endif

    modport master (
`ifdef VSB_HAZARD_EN
        output rd_addr,
        input  rd_hazard,
`endif
        output mem_wr_enable, wr_sc, wr_addr, wd1, wd2, wd3, wd4,
        input  ram_we, ram_addr, ram_wd, full, empty, overflow
    );

    modport slave (
`ifdef VSB_HAZARD_EN
        input  rd_addr,
        output rd_hazard,
`endif
        input  mem_wr_enable, wr_sc, wr_addr, wd1, wd2, wd3, wd4,
        output ram_we, ram_addr, ram_wd, full, empty, overflow
    );
endinterface

// File: rtl/vector_store_buffer.sv
// vector_store_buffer
// Posted-write buffer: captures one scalar or 4-lane vector store per cycle
// into a FIFO and drains it one 32-bit word per cycle into a single-port RAM.
// The CPU is never stalled; stores arriving while full are dropped and
// flagged on the sticky overflow output.
// Ports:
//   clk : clock
//   rst : asynchronous reset, active-high
//   bus : vector_store_buffer_if.slave (store port, RAM port, status)
// Parameter:
//   DEPTH : FIFO entries, power of two, >= 2
// Optional feature macro: VSB_HAZARD_EN adds the combinational read-after-
// write hazard compare (bus.rd_addr -> bus.rd_hazard).
module vector_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic        sc;
        logic [29:0] addr;
        logic [31:0] wd1;
        logic [31:0] wd2;
        logic [31:0] wd3;
        logic [31:0] wd4;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    entry_t        fifo [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    state_t        state, state_next;
    logic [1:0]    lane, lane_next;
    entry_t        cur;
    logic          full_q, ovf_q;
    logic          ram_we_q;
    logic [31:0]   ram_addr_q, ram_wd_q;
    logic          do_push, do_pop, last_lane;
    logic [31:0]   lane_data;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^bus.wr_addr[1:0];

    always_comb begin
        last_lane  = cur.sc ? (lane == 2'd0) : (lane == 2'd3);
        do_push    = bus.mem_wr_enable && !full_q;
        // A pop happens whenever the drain register is free or about to be.
        do_pop     = (count != '0) && ((state == IDLE) || last_lane);
        state_next = state;
        lane_next  = lane;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = DRAIN;
                    lane_next  = 2'd0;
                end
            end
            DRAIN: begin
                if (last_lane) begin
                    if (count == '0) state_next = IDLE;
                    lane_next = 2'd0;
                end else begin
                    lane_next = lane + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        count_next = count;
        if (do_push && !do_pop)      count_next = count + CW'(1);
        else if (!do_push && do_pop) count_next = count - CW'(1);
        lane_data = cur.wd1;
        case (lane)
            2'd1:    lane_data = cur.wd2;
            2'd2:    lane_data = cur.wd3;
            2'd3:    lane_data = cur.wd4;
            default: lane_data = cur.wd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lane       <= 2'd0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cur        <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_wd_q   <= '0;
        end else begin
            state  <= state_next;
            lane   <= lane_next;
            count  <= count_next;
            full_q <= (count_next == DEPTH_C);
            // Judged on the pre-edge full flag, so a simultaneous pop does not save the store.
            if (bus.mem_wr_enable && full_q) ovf_q <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) begin
                cur    <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (state == DRAIN) begin
                ram_we_q   <= 1'b1;
                ram_addr_q <= {cur.addr + 30'(lane), 2'b00};
                ram_wd_q   <= lane_data;
            end else begin
                ram_we_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            fifo[wr_ptr] <= {bus.wr_sc, bus.wr_addr[31:2], bus.wd1, bus.wd2, bus.wd3, bus.wd4};
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_wd   = ram_wd_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
    assign bus.empty    = (count == '0) && (state == IDLE);

`ifdef VSB_HAZARD_EN
    logic [29:0]   rd_word, hz_off, cur_off;
    logic [PW-1:0] hz_idx;
    entry_t        hz_e;
    logic          hz;
    logic          unused_rd_lsb;

    assign rd_word       = bus.rd_addr[31:2];
    assign unused_rd_lsb = ^bus.rd_addr[1:0];

    // Offsets are taken modulo 2^30 so vector entries that wrap past the top still match.
    always_comb begin
        hz     = 1'b0;
        hz_idx = '0;
        hz_e   = '0;
        hz_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_idx = rd_ptr + PW'(i);
            hz_e   = fifo[hz_idx];
            hz_off = rd_word - hz_e.addr;
            if ((CW'(i) < count) && (hz_e.sc ? (hz_off == '0) : (hz_off < 30'd4)))
                hz = 1'b1;
        end
        cur_off = rd_word - cur.addr;
        if ((state == DRAIN) && (cur.sc ? (cur_off == '0) : (cur_off < 30'd4))
            && (cur_off >= 30'(lane)))
            hz = 1'b1;
    end

    assign bus.rd_hazard = hz;
`endif
endmodule

// File: tb/tb_vector_store_buffer.sv
// tb_vector_store_buffer
// Self-checking bench for vector_store_buffer: directed scenarios plus
// randomized stores compared every cycle against a queue-based model of
// pending stores and not-yet-written words.
module tb_vector_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_store_buffer_if bus();
    vector_store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    typedef struct packed {
        logic             sc;
        logic [31:0]      addr;
        logic [3:0][31:0] d;
    } store_t;

    store_t m_q[$];     // accepted stores waiting in the FIFO
    word_t  m_cur[$];   // words of the loaded store not yet put on the RAM port
    bit     m_ovf;
    bit     m_we;
    word_t  m_out;

    int          we_cnt, run, max_run;
    bit          full_seen;
    logic [31:0] last_wr_addr;
    logic [31:0] last_a;

    task automatic clear_stats();
        we_cnt = 0; run = 0; max_run = 0; full_seen = 0; last_wr_addr = '0;
    endtask

    function automatic bit model_hazard(input logic [31:0] rd);
        bit h = 0;
        foreach (m_q[k]) begin
            for (int l = 0; l < (m_q[k].sc ? 1 : 4); l++) begin
                logic [31:0] wa = {m_q[k].addr[31:2], 2'b00} + 32'(4 * l);
                if (wa[31:2] == rd[31:2]) h = 1;
            end
        end
        foreach (m_cur[k]) if (m_cur[k].addr[31:2] == rd[31:2]) h = 1;
        return h;
    endfunction

    task automatic model_step(input bit en, input bit sc, input logic [31:0] a,
                              input logic [3:0][31:0] d);
        int     pre = m_q.size();
        store_t s;
        if (m_cur.size() > 0) begin
            m_we  = 1;
            m_out = m_cur.pop_front();
        end else begin
            m_we = 0;
        end
        if (m_cur.size() == 0 && m_q.size() > 0) begin
            s = m_q.pop_front();
            for (int l = 0; l < (s.sc ? 1 : 4); l++) begin
                word_t w;
                w.addr = {s.addr[31:2], 2'b00} + 32'(4 * l);
                w.data = s.d[l];
                m_cur.push_back(w);
            end
        end
        if (en) begin
            if (pre < DEPTH) begin
                s.sc = sc; s.addr = a; s.d = d;
                m_q.push_back(s);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic tick(input bit en, input bit sc, input logic [31:0] a,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [31:0] d4);
        logic [3:0][31:0] d;
        d = {d4, d3, d2, d1};
        bus.mem_wr_enable = en;
        bus.wr_sc = sc;
        bus.wr_addr = a;
        bus.wd1 = d1; bus.wd2 = d2; bus.wd3 = d3; bus.wd4 = d4;
`ifdef VSB_HAZARD_EN
        if ($urandom_range(0, 1) == 1) bus.rd_addr = last_a + 32'(4 * $urandom_range(0, 4));
        else bus.rd_addr = $urandom;
        #1;
        check("rd_hazard", bus.rd_hazard, model_hazard(bus.rd_addr));
`endif
        if (en) last_a = a;
        @(posedge clk);
        model_step(en, sc, a, d);
        #1;
        check("ram_we", bus.ram_we, m_we);
        if (m_we) begin
            check("ram_addr", bus.ram_addr, m_out.addr);
            check("ram_wd", bus.ram_wd, m_out.data);
        end
        check("full", bus.full, m_q.size() == DEPTH);
        check("empty", bus.empty, (m_q.size() == 0) && (m_cur.size() == 0));
        check("overflow", bus.overflow, m_ovf);
        if (bus.ram_we) begin
            we_cnt++; run++; last_wr_addr = bus.ram_addr;
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
        if (bus.full) full_seen = 1;
        bus.mem_wr_enable = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.mem_wr_enable = 0;
        m_q.delete(); m_cur.delete(); m_ovf = 0; m_we = 0;
        #1;
        check("rst_ram_we", bus.ram_we, 1'b0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        check("rst_ram_wd", bus.ram_wd, 32'h0);
        check("rst_full", bus.full, 1'b0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_overflow", bus.overflow, 1'b0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        bit found;
        rst = 1;
        bus.mem_wr_enable = 0; bus.wr_sc = 0; bus.wr_addr = 0;
        bus.wd1 = 0; bus.wd2 = 0; bus.wd3 = 0; bus.wd4 = 0;
`ifdef VSB_HAZARD_EN
        bus.rd_addr = 0;
`endif
        last_a = 0;
        clear_stats();
        #2;
        do_reset();

        // Scalar store: single pulse two edges after the push.
        clear_stats();
        tick(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        check("t1_n0_we", bus.ram_we, 1'b0);
        idle(1);
        check("t1_n1_we", bus.ram_we, 1'b0);
        idle(1);
        check("t1_n2_we", bus.ram_we, 1'b1);
        check("t1_n2_addr", bus.ram_addr, 32'h100);
        check("t1_n2_wd", bus.ram_wd, 32'hDEADBEEF);
        idle(1);
        check("t1_n3_we", bus.ram_we, 1'b0);
        check("t1_empty", bus.empty, 1'b1);
        idle(4);
        check("t1_pulses", we_cnt, 1);

        // Vector store: four consecutive words.
        clear_stats();
        tick(1, 0, 32'h200, 1, 2, 3, 4);
        idle(8);
        check("t2_writes", we_cnt, 4);
        check("t2_run", max_run, 4);
        check("t2_last", last_wr_addr, 32'h20C);

        // Vector then scalar back-to-back: no bubble.
        clear_stats();
        tick(1, 0, 32'h0, $urandom, $urandom, $urandom, $urandom);
        tick(1, 1, 32'h40, 32'h5A5A5A5A, 0, 0, 0);
        idle(10);
        check("t3_writes", we_cnt, 5);
        check("t3_run", max_run, 5);
        check("t3_last", last_wr_addr, 32'h40);

        // Six vector stores in a row overflow a 4-deep buffer by one.
        clear_stats();
        for (int i = 0; i < 6; i++)
            tick(1, 0, 32'h1000 + 32'(16 * i), $urandom, $urandom, $urandom, $urandom);
        idle(30);
        check("t4_full_seen", full_seen, 1'b1);
        check("t4_writes", we_cnt, 20);
        check("t4_run", max_run, 20);
        check("t4_overflow", bus.overflow, 1'b1);
        idle(5);
        check("t4_ovf_sticky", bus.overflow, 1'b1);

        // Address wrap and ignored low address bits.
        clear_stats();
        tick(1, 0, 32'hFFFFFFF9, $urandom, $urandom, $urandom, $urandom);
        idle(8);
        check("t5_writes", we_cnt, 4);
        check("t5_wrap_last", last_wr_addr, 32'h4);

        // Reset while lane 2 of a vector is on the RAM port.
        do_reset();
        clear_stats();
        tick(1, 0, 32'h500, 11, 22, 33, 44);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1);
            if (bus.ram_we && bus.ram_addr == 32'h508) found = 1;
        end
        check("t6_lane2_seen", found, 1'b1);
        do_reset();
        clear_stats();
        idle(10);
        check("t6_no_writes", we_cnt, 0);
        check("t6_empty", bus.empty, 1'b1);

`ifdef VSB_HAZARD_EN
        tick(1, 0, 32'h300, 5, 6, 7, 8);
        bus.rd_addr = 32'h30C; #1;
        check("hz_30c", bus.rd_hazard, 1'b1);
        bus.rd_addr = 32'h310; #1;
        check("hz_310", bus.rd_hazard, 1'b0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            idle(1);
            if (bus.ram_we && bus.ram_addr == 32'h304) found = 1;
        end
        check("hz_lane1_seen", found, 1'b1);
        bus.rd_addr = 32'h300; #1;
        check("hz_300_done", bus.rd_hazard, 1'b0);
        bus.rd_addr = 32'h308; #1;
        check("hz_308_pend", bus.rd_hazard, 1'b1);
        idle(8);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                            : $urandom;
            tick($urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1, a,
                 $urandom, $urandom, $urandom, $urandom);
        end
        idle(30);
        check("rand_drained", bus.empty, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
